receiver: RTL
=============

# receiver

Serial-to-parallel UART receive stage, the downstream counterpart of the transmitter on the link. It oversamples the synchronised RX line at 16x using the shared baud-rate tick and validates start and stop bits. Received 5–8 bit words go into an internal first-word-fall-through (FWFT) FIFO. The block also detects the 10 ms line-low configuration request that a transmitter sends, and reports it to the controller.

## Interface

Parameters:
- `SYSTEM_CLOCK_FREQ`, default 100_000_000: clock frequency in Hz. `COUNT_10MS = SYSTEM_CLOCK_FREQ/100`.
- `RX_FIFO_DEPTH`, default 16: FIFO depth in words; must be a power of 2, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` input 1: system clock.
- `rst_n_i` input 1: asynchronous active-low reset.
- `rx_i` input 1: serial line, asynchronous to `clk_i`; idle level is 1.
- `ov_baud_rt_i` input 1: one-cycle tick at 16x the baud rate.
- `data_width_i` input 2: word width. 00 = 5, 01 = 6, 10 = 7, 11 = 8 bits.
- `stop_bits_number_i` input 2: stop bits. 01 = 2 stop bits; any other value = 1 stop bit.
- `rx_fifo_read_i` input 1: pops the head word. Ignored when the FIFO is empty.
- `rx_data_o` output 8: FIFO head word, zero-extended; 0 when empty.
- `rx_done_o` output 1: one-cycle pulse when a valid frame is pushed.
- `frame_error_o` output 1: one-cycle pulse when a stop bit samples 0.
- `overrun_error_o` output 1: one-cycle pulse when a valid frame arrives while the FIFO is full.
- `config_req_slv_o` output 1: one-cycle pulse when the line has been low for `COUNT_10MS` cycles.
- `rx_fifo_empty_o` output 1: FIFO empty.
- `rx_fifo_full_o` output 1: FIFO full.

## Operation

- **Synchroniser:** 2-flop synchroniser on `rx_i`, reset to 1. All logic uses the synchronised value `rxs`.
- **Counters:** `tick_cnt` is 4 bits and advances only on `ov_baud_rt_i`. `bit_cnt` is 3 bits. Shift register `shreg` is 8 bits.
- **FSM states and transitions:**
  - IDLE: when `rxs == 0`, clear `tick_cnt` and go to START.
  - START: on a tick with `tick_cnt == 7`, re-check `rxs`.
    - `rxs == 0`: clear `tick_cnt` and `bit_cnt`, go to DATA.
    - `rxs == 1`: glitch; go to IDLE with no output.
  - DATA: on a tick with `tick_cnt == 15`, sample one bit (`shreg = {rxs, shreg[7:1]}`, LSB first) and increment `bit_cnt`.
    - After the bit with `bit_cnt == width-1`, go to STOP.
  - STOP: on a tick with `tick_cnt == 15`, sample `rxs`.
    - `rxs == 0`: pulse `frame_error_o`, discard the word, go to IDLE.
    - Two stop bits configured and the first stop bit sampled: stay in STOP for the second.
    - Final stop bit good: push the word `shreg >> (8-width)`; pulse `rx_done_o`, or `overrun_error_o` instead if the FIFO is full (word dropped). Go to IDLE.
  - BREAK: entered from any state when the low-time counter reaches `COUNT_10MS`. Pulse `config_req_slv_o` once and discard any partial frame. Stay in BREAK until `rxs == 1`, then go to IDLE.
- **Low-time counter:** `$clog2(COUNT_10MS+1)` bits. Clears whenever `rxs == 1`, increments while `rxs == 0`, and saturates in BREAK.
- **Configuration sampling:** `data_width_i` and `stop_bits_number_i` are sampled on entry to START and held for the rest of the frame.
- **FIFO (FWFT):**
  - Head word is valid on `rx_data_o` whenever not empty.
  - Read and write in the same cycle are both performed.
  - Overrun is judged on `rx_fifo_full_o` in the push cycle; a read in that same cycle does not prevent the overrun.
  - Pointers wrap modulo `RX_FIFO_DEPTH`.

## Timing

- **Reset values:** FSM in IDLE; all counters and `shreg` 0; synchroniser 1; FIFO empty. `rx_data_o = 0`, `rx_fifo_empty_o = 1`, `rx_fifo_full_o = 0`; all pulse outputs 0.
- **Sample points:** the start bit is checked on the 8th tick after the falling edge is seen; data and stop bits every 16 ticks after that (bit centres).
- **Synchroniser latency:** 2 cycles from `rx_i` to `rxs`.
- **Push latency:** the FIFO push and the `rx_done_o` / `overrun_error_o` / `frame_error_o` pulse happen in the cycle after the final stop-bit sampling tick.
  - `rx_fifo_empty_o` falls and `rx_data_o` is valid in the following cycle.
- **Read latency:** after a pop, `rx_data_o` shows the next word, and the empty/full flags update, the cycle after `rx_fifo_read_i`.
- **Break timing:** `config_req_slv_o` pulses exactly `COUNT_10MS` cycles after `rxs` falls, provided it stays low.
- **Mutual exclusion:** at most one of `rx_done_o`, `frame_error_o`, `overrun_error_o` is asserted in any cycle.
- **Reset mid-frame:** the partial frame is lost, the FIFO is cleared, and no pulses are generated.

## Test plan

In all scenarios `ov_baud_rt_i` is tied to 1 (one bit = 16 clocks), and `SYSTEM_CLOCK_FREQ` = 100_000, so `COUNT_10MS` = 1000.
- **8N1 frame:** drive 0xA5 with width 11 and stop 00 -> one `rx_done_o` pulse; `rx_data_o` = 0xA5, empty = 0; one read -> empty = 1, `rx_data_o` = 0.
- **5-bit, 2 stop bits:** drive 0x15 with width 00 and stop 01 -> `rx_done_o` only after the second stop bit; `rx_data_o` = 0x15.
- **Glitch:** pull the line low for 4 clocks, then high -> FSM returns to IDLE; no pulses; FIFO stays empty.
- **Framing error:** drive 0x3C with the stop bit = 0 -> `frame_error_o` pulses; FIFO stays empty; the next valid frame 0x55 is received correctly.
- **Overrun:** send 17 frames 0x00..0x10 without reading -> full = 1 after the 16th; the 17th pulses `overrun_error_o`; reads return 0x00..0x0F in order.
- **Break and reset:**
  - Hold the line low for 1000 cycles -> `config_req_slv_o` pulses once; release -> IDLE.
  - Assert reset at mid-frame bit 3 -> all outputs at reset values; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/receiver.sv
// UART receive stage: 2-flop RX synchroniser, 16x oversampling frame FSM
// with start/stop validation, 10 ms line-low (config request) detection,
// and a first-word-fall-through FIFO for the received 5..8 bit words.
`timescale 1ns/1ps
module receiver #(
    parameter int SYSTEM_CLOCK_FREQ = 100_000_000,
    parameter int RX_FIFO_DEPTH     = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    input  logic       ov_baud_rt_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] stop_bits_number_i,
    input  logic       rx_fifo_read_i,
    output logic [7:0] rx_data_o,
    output logic       rx_done_o,
    output logic       frame_error_o,
    output logic       overrun_error_o,
    output logic       config_req_slv_o,
    output logic       rx_fifo_empty_o,
    output logic       rx_fifo_full_o
);

    localparam int COUNT_10MS = SYSTEM_CLOCK_FREQ / 100;
    localparam int LOW_W      = $clog2(COUNT_10MS + 1);
    localparam int AW         = $clog2(RX_FIFO_DEPTH);

    localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(COUNT_10MS);
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(RX_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Low-time counter increment that sticks at the break threshold.
    function automatic logic [LOW_W-1:0] low_sat_inc(input logic [LOW_W-1:0] v);
        return (v == LOW_MAX) ? v : v + 1'b1;
    endfunction

    // Right-align the LSB-first shift register for the configured width.
    function automatic logic [7:0] align_word(input logic [7:0] sr, input logic [1:0] wc);
        return sr >> (3'd3 - {1'b0, wc});
    endfunction

    logic             rx_meta, rxs;
    state_t           state, state_nx;
    logic [3:0]       tick_cnt, tick_nx;
    logic [2:0]       bit_cnt, bit_nx;
    logic [7:0]       shreg, shreg_nx;
    logic [1:0]       width_q, width_nx;
    logic             two_stop_q, two_stop_nx;
    logic             stop2_q, stop2_nx;
    logic [LOW_W-1:0] low_cnt;
    logic             brk_hit;

    logic             push_vld_p1, push_vld_nx;
    logic [7:0]       push_word_p1, push_word_nx;
    logic             ferr_p1, ferr_nx;

    logic [7:0]       mem [RX_FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             wr_en, rd_en;

    // Bring the asynchronous line into the clock domain; idle level is 1.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    // Count consecutive low cycles; saturating holds the count while in BREAK.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            low_cnt <= '0;
        end else if (rxs) begin
            low_cnt <= '0;
        end else begin
            low_cnt <= low_sat_inc(low_cnt);
        end
    end

    assign brk_hit          = (state != S_BREAK) && (low_cnt == LOW_MAX);
    assign config_req_slv_o = brk_hit;

    // Frame FSM: next state, counters, shift register and push/error requests.
    always_comb begin
        state_nx     = state;
        tick_nx      = tick_cnt;
        bit_nx       = bit_cnt;
        shreg_nx     = shreg;
        width_nx     = width_q;
        two_stop_nx  = two_stop_q;
        stop2_nx     = stop2_q;
        push_vld_nx  = 1'b0;
        push_word_nx = push_word_p1;
        ferr_nx      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    tick_nx     = '0;
                    width_nx    = data_width_i;
                    two_stop_nx = (stop_bits_number_i == 2'b01);
                    state_nx    = S_START;
                end
            end
            S_START: begin
                if (ov_baud_rt_i) begin
                    if (tick_cnt == 4'd7) begin
                        if (!rxs) begin
                            tick_nx  = '0;
                            bit_nx   = '0;
                            state_nx = S_DATA;
                        end else begin
                            state_nx = S_IDLE;
                        end
                    end else begin
                        tick_nx = tick_cnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (ov_baud_rt_i) begin
                    tick_nx = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shreg_nx = {rxs, shreg[7:1]};
                        bit_nx   = bit_cnt + 3'd1;
                        // Last data bit index is width-1 = 4 + width code.
                        if (bit_cnt == {1'b1, width_q}) begin
                            stop2_nx = 1'b0;
                            state_nx = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (ov_baud_rt_i) begin
                    tick_nx = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (!rxs) begin
                            ferr_nx  = 1'b1;
                            state_nx = S_IDLE;
                        end else if (two_stop_q && !stop2_q) begin
                            stop2_nx = 1'b1;
                        end else begin
                            push_vld_nx  = 1'b1;
                            push_word_nx = align_word(shreg, width_q);
                            state_nx     = S_IDLE;
                        end
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // A long low line overrides any frame in progress.
        if (brk_hit) begin
            state_nx    = S_BREAK;
            push_vld_nx = 1'b0;
            ferr_nx     = 1'b0;
        end
    end

    // Frame FSM state and control registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            width_q     <= '0;
            two_stop_q  <= 1'b0;
            stop2_q     <= 1'b0;
            push_vld_p1 <= 1'b0;
            ferr_p1     <= 1'b0;
        end else begin
            state       <= state_nx;
            tick_cnt    <= tick_nx;
            bit_cnt     <= bit_nx;
            shreg       <= shreg_nx;
            width_q     <= width_nx;
            two_stop_q  <= two_stop_nx;
            stop2_q     <= stop2_nx;
            push_vld_p1 <= push_vld_nx;
            ferr_p1     <= ferr_nx;
        end
    end

    // Aligned word travelling with push_vld_p1 into the FIFO.
    always_ff @(posedge clk_i) begin
        push_word_p1 <= push_word_nx;
    end

    // ---- push stage: FIFO write and result pulses ----
    assign rx_fifo_empty_o = (count == '0);
    assign rx_fifo_full_o  = (count == DEPTH_C);
    assign wr_en           = push_vld_p1 && !rx_fifo_full_o;
    assign rd_en           = rx_fifo_read_i && !rx_fifo_empty_o;
    assign rx_done_o       = push_vld_p1 && !rx_fifo_full_o;
    assign overrun_error_o = push_vld_p1 && rx_fifo_full_o;
    assign frame_error_o   = ferr_p1;
    assign rx_data_o       = rx_fifo_empty_o ? 8'h00 : mem[rd_ptr];

    // FIFO storage; contents are only visible when the count says so.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word_p1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
